// File: rtl/wheel_gen_if.sv
// Command/encoder bundle between a wheel quadrature generator and its controller.
// The abort signal exists only when WHEEL_GEN_ABORT_EN is defined.
interface wheel_gen_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             dir_ccw;
  logic [CNT_W-1:0] steps;
`ifdef WHEEL_GEN_ABORT_EN
  logic             abort;
`endif
  logic             pin1;
  logic             pin2;
  logic             busy;
  logic             ready;
  logic             step_done;
  logic             done;

  modport master (
`ifdef WHEEL_GEN_ABORT_EN
    output abort,
`endif
    output start, dir_ccw, steps,
    input  pin1, pin2, busy, ready, step_done, done
  );

  modport slave (
`ifdef WHEEL_GEN_ABORT_EN
    input  abort,
`endif
    input  start, dir_ccw, steps,
    output pin1, pin2, busy, ready, step_done, done
  );
endinterface

// File: rtl/wheel_quadrature_gen.sv
// Quadrature wheel encoder emulator: emits N full Gray-code cycles on {pin2,pin1}.
// Optional feature macro: WHEEL_GEN_ABORT_EN (adds an abort input that ends a command early).
module wheel_quadrature_gen #(
  parameter int PHASE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  wheel_gen_if.slave bus
);
  localparam int            PW      = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_PH3, S_PH4} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_phase_cnt;
  logic [CNT_W-1:0] r_remaining;
  logic             r_dir_ccw;
  logic [1:0]       r_pins;
  logic             r_busy;
  logic             r_step_done;
  logic             r_done;
  logic             w_abort;
  logic             w_phase_end;

  // {pin2,pin1} per phase; CW 01,11,10,00 and CCW 10,11,01,00.
  function automatic logic [1:0] phase_pins(input state_t s, input logic ccw);
    case (s)
      S_PH1:   phase_pins = ccw ? 2'b10 : 2'b01;
      S_PH2:   phase_pins = 2'b11;
      S_PH3:   phase_pins = ccw ? 2'b01 : 2'b10;
      default: phase_pins = 2'b00;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_PH1:   next_phase = S_PH2;
      S_PH2:   next_phase = S_PH3;
      S_PH3:   next_phase = S_PH4;
      default: next_phase = S_PH1;
    endcase
  endfunction

`ifdef WHEEL_GEN_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_phase_end = (r_phase_cnt == PH_LAST);

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= '0;
      r_remaining <= '0;
      r_dir_ccw   <= 1'b0;
      r_pins      <= 2'b00;
      r_busy      <= 1'b0;
      r_step_done <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      r_done      <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.start) begin
          if (bus.steps != '0) begin
            r_state     <= S_PH1;
            r_dir_ccw   <= bus.dir_ccw;
            r_remaining <= bus.steps;
            r_phase_cnt <= '0;
            r_pins      <= phase_pins(S_PH1, bus.dir_ccw);
            r_busy      <= 1'b1;
          end else begin
            r_done <= 1'b1;
          end
        end
      end else if (w_abort) begin
        // Partial step is dropped: no step_done, pins straight back to rest.
        r_state     <= S_IDLE;
        r_phase_cnt <= '0;
        r_remaining <= '0;
        r_pins      <= 2'b00;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
      end else if (!w_phase_end) begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
      end else begin
        r_phase_cnt <= '0;
        if (r_state != S_PH4) begin
          r_state <= next_phase(r_state);
          r_pins  <= phase_pins(next_phase(r_state), r_dir_ccw);
        end else begin
          r_step_done <= 1'b1;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining > CNT_W'(1)) begin
            r_state <= S_PH1;
            r_pins  <= phase_pins(S_PH1, r_dir_ccw);
          end else begin
            r_state <= S_IDLE;
            r_pins  <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.pin1      = r_pins[0];
  assign bus.pin2      = r_pins[1];
  assign bus.busy      = r_busy;
  assign bus.ready     = ~r_busy;
  assign bus.step_done = r_step_done;
  assign bus.done      = r_done;
endmodule
